mem_loader: RTL
===============

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the memory address width.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 4096, meaning the number of byte locations addressed.
REQ-003 The block SHALL have parameter FONT_BASE, default 0, meaning the first address of the fontset.
REQ-004 The block SHALL have parameter PROG_BASE, default 12'h200, meaning the first address of the program image.
REQ-005 The block SHALL have parameter CLEAR_MEM, default 1, meaning zero-fill memory before loading (0 = skip the fill).
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset: clk_in  input  1  clock, all state on its rising edge.
REQ-007 The block SHALL have port rst_in  input  1  asynchronous active-high reset.
REQ-008 The block SHALL have port start_in  input  1  load request, sampled in IDLE or DONE.
REQ-009 The block SHALL have port rom_valid_in  input  1  program byte valid.
REQ-010 The block SHALL have port rom_data_in  input  8  program byte.
REQ-011 The block SHALL have port rom_last_in  input  1  final program byte, qualified by valid.
REQ-012 The block SHALL have port rom_ready_out  output  1  block accepts a program byte.
REQ-013 The block SHALL have port mem_we_out  output  1  memory write strobe.
REQ-014 The block SHALL have port mem_addr_out  output  ADDR_W  write address.
REQ-015 The block SHALL have port mem_wdata_out  output  8  write data.
REQ-016 The block SHALL have port busy_out  output  1  load in progress.
REQ-017 The block SHALL have port done_out  output  1  load complete (level).
REQ-018 The block SHALL have port overflow_out  output  1  program hit end of memory without rom_last_in.
REQ-019 The block SHALL have port prog_len_out  output  ADDR_W+1  count of program bytes written.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, FONT, PROG, DONE; all outputs SHALL be registered.
REQ-021 start_in in IDLE or DONE SHALL enter CLEAR (CLEAR_MEM=1) or FONT (CLEAR_MEM=0) next cycle, clearing done_out, overflow_out and prog_len_out; start_in in other states SHALL be ignored.
REQ-022 CLEAR SHALL write 8'h00 to addresses 0..MEM_DEPTH-1 ascending, one per cycle, then enter FONT.
REQ-023 FONT SHALL write the 80 fontset bytes (glyphs 0..F, 5 bytes each, byte i to FONT_BASE+i) on 80 consecutive cycles, then enter PROG.
REQ-024 In PROG, rom_ready_out SHALL be 1; each cycle with rom_valid_in=1 SHALL write rom_data_in to PROG_BASE+prog_len_out on the following cycle and increment prog_len_out.
REQ-025 rom_valid_in low in PROG SHALL produce no write and SHALL hold the state indefinitely.
REQ-026 An accepted byte with rom_last_in=1 SHALL be written, then the FSM SHALL enter DONE.
REQ-027 When an accepted byte lands at address MEM_DEPTH-1 without rom_last_in, the FSM SHALL enter DONE with overflow_out=1; rom_ready_out SHALL deassert in the same cycle so no further byte is accepted.
REQ-028 busy_out SHALL be 1 exactly in CLEAR, FONT and PROG; done_out SHALL be 1 exactly in DONE.
REQ-029 mem_we_out SHALL be 0 in IDLE and DONE; rom_ready_out SHALL be 0 outside PROG.
REQ-030 Address arithmetic SHALL be ADDR_W bits without wrap; PROG_BASE+80 overlap with fontset is a configuration error, not checked.

Reset
REQ-031 rst_in SHALL force IDLE with every output 0, including mid-load; memory contents already written SHALL NOT be restored.
REQ-032 A start_in after reset SHALL restart the full sequence from the beginning.

Structure
REQ-033 The fontset table, glyph height (5), glyph count (16) and FSM state enum SHALL live in shared package chip8_pkg.
REQ-034 A sub-module font_rom SHALL map a 7-bit index to a font byte combinationally.

Verification
REQ-035 CLEAR_MEM=1, start, stream 3 bytes AA,BB,CC (last on CC) -> 4096 zero writes, 80 font writes (addr 0 = F0, addr 79 = 80), then 200=AA, 201=BB, 202=CC, done_out=1, prog_len_out=3.
REQ-036 CLEAR_MEM=0, start -> first write is addr 0 = F0 on cycle 1 after start, no zero writes.
REQ-037 Stream 3584 bytes, no last -> final write addr FFF, overflow_out=1, rom_ready_out=0, byte 3585 held unaccepted.
REQ-038 Gaps in rom_valid_in (1 on, 3 off, repeat) -> writes only on accepted bytes, contiguous addresses.
REQ-039 rst_in pulse during FONT at index 40 -> next cycle all outputs 0, state IDLE; new start repeats full sequence.
REQ-040 start_in pulsed during PROG -> ignored, prog_len_out continues incrementing.

Source files
------------

// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_pkg
//  Purpose  : Shared definitions for the CHIP-8 memory loader: glyph geometry,
//             the built-in hexadecimal fontset and the loader FSM state enum.
//  Revision : 1.0  initial release
// ============================================================================
package chip8_pkg;

    localparam int FONT_HEIGHT = 5;
    localparam int FONT_GLYPHS = 16;
    localparam int FONT_BYTES  = FONT_HEIGHT * FONT_GLYPHS;

    // Glyphs 0..F, five rows each, row bits in the upper nibble.
    localparam logic [7:0] FONTSET [0:FONT_BYTES-1] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FONT  = 3'd2,
        PROG  = 3'd3,
        DONE  = 3'd4
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/font_rom.sv
`default_nettype none
// ============================================================================
//  Module   : font_rom
//  Purpose  : Combinational lookup of one fontset byte by linear index.
//             Indices past the end of the table read as zero.
//  Revision : 1.0  initial release
// ============================================================================
module font_rom
    import chip8_pkg::*;
(
    input  logic [6:0] idx,
    output logic [7:0] data
);

    // Table lookup with an out-of-range guard.
    always_comb begin
        data = 8'h00;
        if (idx < 7'(FONT_BYTES)) begin
            data = FONTSET[idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_loader
//  Purpose  : Boot-time memory initialiser. Optionally zero-fills memory,
//             writes the fontset, then streams a program image from a
//             valid/ready byte source into memory starting at PROG_BASE.
//  Revision : 1.0  initial release
// ============================================================================
module mem_loader
    import chip8_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096,
    parameter int FONT_BASE = 0,
    parameter int PROG_BASE = 'h200,
    parameter int CLEAR_MEM = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              rom_valid_in,
    input  logic [7:0]        rom_data_in,
    input  logic              rom_last_in,
    output logic              rom_ready_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [7:0]        mem_wdata_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              overflow_out,
    output logic [ADDR_W:0]   prog_len_out
);

    localparam int                CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CLEAR_LAST = CNT_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FONT_LAST  = CNT_W'(FONT_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] FONT_BASE_A = ADDR_W'(FONT_BASE);
    localparam logic [ADDR_W-1:0] PROG_BASE_A = ADDR_W'(PROG_BASE);

    load_state_t       state, state_nxt;
    logic [CNT_W-1:0]  idx, idx_nxt;          // index of the clear/font write in flight
    logic              finishing, finishing_nxt; // final program byte is being written
    logic              ovf_pend, ovf_nxt;     // load is ending by running out of memory

    logic              we_nxt, ready_nxt, busy_nxt, done_nxt, overflow_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdata_nxt;
    logic [ADDR_W:0]   len_nxt;

    logic              accept;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        font_byte;

    assign accept    = (state == PROG) && rom_ready_out && rom_valid_in;
    assign prog_addr = PROG_BASE_A + prog_len_out[ADDR_W-1:0];

    // The font byte is looked up for the index that will be written next cycle.
    font_rom u_font_rom (
        .idx  (idx_nxt[6:0]),
        .data (font_byte)
    );

    // State register and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            idx           <= '0;
            finishing     <= 1'b0;
            ovf_pend      <= 1'b0;
            rom_ready_out <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            overflow_out  <= 1'b0;
            prog_len_out  <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            finishing     <= finishing_nxt;
            ovf_pend      <= ovf_nxt;
            rom_ready_out <= ready_nxt;
            mem_we_out    <= we_nxt;
            mem_addr_out  <= addr_nxt;
            mem_wdata_out <= wdata_nxt;
            busy_out      <= busy_nxt;
            done_out      <= done_nxt;
            overflow_out  <= overflow_nxt;
            prog_len_out  <= len_nxt;
        end
    end

    // Next-state logic, then outputs derived from the state being entered so
    // that every output lines up with the state it belongs to.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        finishing_nxt = finishing;
        ovf_nxt       = ovf_pend;
        len_nxt       = prog_len_out;
        we_nxt        = 1'b0;
        addr_nxt      = '0;
        wdata_nxt     = '0;
        ready_nxt     = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        overflow_nxt  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start_in) begin
                    state_nxt     = (CLEAR_MEM != 0) ? CLEAR : FONT;
                    idx_nxt       = '0;
                    len_nxt       = '0;
                    finishing_nxt = 1'b0;
                    ovf_nxt       = 1'b0;
                end
            end
            CLEAR: begin
                if (idx == CLEAR_LAST) begin
                    state_nxt = FONT;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
            FONT: begin
                if (idx == FONT_LAST) begin
                    state_nxt = PROG;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
            PROG: begin
                if (finishing) begin
                    state_nxt = DONE;
                end else if (accept) begin
                    len_nxt = prog_len_out + (ADDR_W+1)'(1);
                    if (rom_last_in) begin
                        finishing_nxt = 1'b1;
                    end else if (prog_addr == ADDR_LAST) begin
                        // Top of memory reached with more image pending.
                        finishing_nxt = 1'b1;
                        ovf_nxt       = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            CLEAR: begin
                we_nxt   = 1'b1;
                addr_nxt = idx_nxt[ADDR_W-1:0];
                busy_nxt = 1'b1;
            end
            FONT: begin
                we_nxt    = 1'b1;
                addr_nxt  = FONT_BASE_A + idx_nxt[ADDR_W-1:0];
                wdata_nxt = font_byte;
                busy_nxt  = 1'b1;
            end
            PROG: begin
                busy_nxt  = 1'b1;
                // Stop accepting as soon as the final byte has been taken.
                ready_nxt = !finishing_nxt;
                if (accept) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = prog_addr;
                    wdata_nxt = rom_data_in;
                end
            end
            DONE: begin
                done_nxt     = 1'b1;
                overflow_nxt = ovf_nxt;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
